// File: rtl/qspi_cmd_sequencer.sv
// Deserialises oversampled QSPI nibble frames into board/engine commands; strobes land <= SYNC_STAGES+2 clk after the final sck rise.
// No backpressure: refused accesses while eng_busy set sticky err instead of stalling the host.
module qspi_cmd_sequencer #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] BUSY_NIBBLE = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [3:0] sdi,
  output logic [3:0] sdo,
  output logic       sdo_oe,
  output logic [5:0] brd_addr,
  output logic [3:0] brd_wdata,
  output logic       brd_we,
  output logic       brd_re,
  input  logic [3:0] brd_rdata,
  output logic       eng_start,
  input  logic       eng_busy,
  input  logic [5:0] eng_from,
  input  logic [5:0] eng_to
);

  typedef enum logic [3:0] {
    S_IDLE, S_OPC_HI, S_OPC_LO, S_ADDR_HI, S_ADDR_LO, S_DATA, S_TURN, S_REPLY, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0]      sck_s, cs_s;
  logic [SYNC_STAGES-1:0][3:0] sdi_s;
  logic                        sck_prev;
  logic                        sck_rise, sck_fall, cs_hi;
  logic [3:0]                  sdi_v;

  // cs sync resets to "selected" so a frame cut by rst cannot re-arm until cs_n is really seen high
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s    <= '0;
      cs_s     <= '0;
      sdi_s    <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_s    <= {sck_s[SYNC_STAGES-2:0], sck};
      cs_s     <= {cs_s[SYNC_STAGES-2:0], cs_n};
      sdi_s    <= {sdi_s[SYNC_STAGES-2:0], sdi};
      sck_prev <= sck_s[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_s[SYNC_STAGES-1] & ~sck_prev;
  assign sck_fall = ~sck_s[SYNC_STAGES-1] & sck_prev;
  assign cs_hi    = cs_s[SYNC_STAGES-1];
  assign sdi_v    = sdi_s[SYNC_STAGES-1];

  state_t      state, state_d;
  logic        armed, armed_d;
  logic [3:0]  opc_hi, opc_hi_d;
  logic        is_rd, is_rd_d;
  logic [5:0]  addr, addr_d;
  logic [15:0] reply_sr, reply_sr_d;
  logic [2:0]  rcnt, rcnt_d, rlen, rlen_d;
  logic        rd_pend;
  logic        err, err_d;
  logic [3:0]  sdo_d, brd_wdata_d;
  logic [5:0]  brd_addr_d;
  logic        sdo_oe_d, brd_we_d, brd_re_d, eng_start_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      armed     <= 1'b0;
      opc_hi    <= '0;
      is_rd     <= 1'b0;
      addr      <= '0;
      reply_sr  <= '0;
      rcnt      <= '0;
      rlen      <= '0;
      rd_pend   <= 1'b0;
      err       <= 1'b0;
      sdo       <= '0;
      sdo_oe    <= 1'b0;
      brd_addr  <= '0;
      brd_wdata <= '0;
      brd_we    <= 1'b0;
      brd_re    <= 1'b0;
      eng_start <= 1'b0;
    end else begin
      state     <= state_d;
      armed     <= armed_d;
      opc_hi    <= opc_hi_d;
      is_rd     <= is_rd_d;
      addr      <= addr_d;
      reply_sr  <= reply_sr_d;
      rcnt      <= rcnt_d;
      rlen      <= rlen_d;
      rd_pend   <= brd_re;
      err       <= err_d;
      sdo       <= sdo_d;
      sdo_oe    <= sdo_oe_d;
      brd_addr  <= brd_addr_d;
      brd_wdata <= brd_wdata_d;
      brd_we    <= brd_we_d;
      brd_re    <= brd_re_d;
      eng_start <= eng_start_d;
    end
  end

  always_comb begin
    state_d     = state;
    armed_d     = armed | cs_hi;
    opc_hi_d    = opc_hi;
    is_rd_d     = is_rd;
    addr_d      = addr;
    reply_sr_d  = reply_sr;
    rcnt_d      = rcnt;
    rlen_d      = rlen;
    err_d       = err;
    sdo_d       = sdo;
    sdo_oe_d    = sdo_oe;
    brd_addr_d  = brd_addr;
    brd_wdata_d = brd_wdata;
    brd_we_d    = 1'b0;
    brd_re_d    = 1'b0;
    eng_start_d = 1'b0;

    // board RAM answers one cycle after brd_re; park the data as the reply nibble
    if (rd_pend) reply_sr_d[15:12] = brd_rdata;

    if (cs_hi) begin
      state_d  = S_IDLE;
      sdo_oe_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (armed) begin
          state_d = S_OPC_HI;
          armed_d = 1'b0;
        end
        S_OPC_HI: if (sck_rise) begin
          opc_hi_d = sdi_v;
          state_d  = S_OPC_LO;
        end
        S_OPC_LO: if (sck_rise) begin
          case ({opc_hi, sdi_v})
            8'h01: begin is_rd_d = 1'b0; state_d = S_ADDR_HI; end
            8'h02: begin is_rd_d = 1'b1; state_d = S_ADDR_HI; end
            8'h03: begin
              if (!eng_busy) eng_start_d = 1'b1;
              else           err_d       = 1'b1;
              state_d = S_IGNORE;
            end
            8'h04: begin
              reply_sr_d = {eng_busy, err, 2'b00, eng_from, eng_to};
              err_d      = 1'b0;
              rlen_d     = 3'd4;
              rcnt_d     = 3'd0;
              state_d    = S_REPLY;
            end
            default: state_d = S_IGNORE;
          endcase
        end
        S_ADDR_HI: if (sck_rise) begin
          addr_d[5:4] = sdi_v[1:0];
          state_d     = S_ADDR_LO;
        end
        S_ADDR_LO: if (sck_rise) begin
          addr_d[3:0] = sdi_v;
          if (is_rd) begin
            brd_addr_d = {addr[5:4], sdi_v};
            if (!eng_busy) begin
              brd_re_d = 1'b1;
            end else begin
              reply_sr_d = {BUSY_NIBBLE, 12'h000};
              err_d      = 1'b1;
            end
            rlen_d  = 3'd1;
            rcnt_d  = 3'd0;
            state_d = S_TURN;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: if (sck_rise) begin
          brd_addr_d  = addr;
          brd_wdata_d = sdi_v;
          if (!eng_busy) brd_we_d = 1'b1;
          else           err_d    = 1'b1;
          state_d = S_IGNORE;
        end
        S_TURN: if (sck_rise) state_d = S_REPLY;
        S_REPLY: begin
          if (sck_fall) begin
            sdo_d      = reply_sr[15:12];
            reply_sr_d = {reply_sr[11:0], 4'h0};
            sdo_oe_d   = 1'b1;
            rcnt_d     = rcnt + 3'd1;
          end else if (sck_rise && rcnt == rlen) begin
            // host has sampled the last nibble on this rise
            sdo_oe_d = 1'b0;
            state_d  = S_IGNORE;
          end
        end
        S_IGNORE: state_d = S_IGNORE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_cmd_sequencer.sv
// Bench for qspi_cmd_sequencer: directed frames then random frames against a board/err/engine reference model.
module tb_qspi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, sck, cs_n;
  logic [3:0] sdi;
  logic [3:0] sdo;
  logic       sdo_oe;
  logic [5:0] brd_addr;
  logic [3:0] brd_wdata;
  logic       brd_we, brd_re;
  logic [3:0] brd_rdata = 4'h0;
  logic       eng_start, eng_busy;
  logic [5:0] eng_from, eng_to;

  qspi_cmd_sequencer #(.SYNC_STAGES(2), .BUSY_NIBBLE(4'hF)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe),
    .brd_addr(brd_addr), .brd_wdata(brd_wdata), .brd_we(brd_we), .brd_re(brd_re),
    .brd_rdata(brd_rdata),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_from(eng_from), .eng_to(eng_to)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // board RAM seen by the DUT: registered read, one-cycle latency
  logic [3:0] ram [64] = '{default: 4'h0};
  always @(posedge clk) begin
    if (brd_we) ram[brd_addr] <= brd_wdata;
    if (brd_re) brd_rdata <= ram[brd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         we_cnt = 0, re_cnt = 0, st_cnt = 0, viol = 0, we_cyc = 0, st_cyc = 0;
  logic [5:0] we_addr = '0, re_addr = '0;
  logic [3:0] we_data = '0;
  always @(negedge clk) begin
    if (brd_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= brd_addr;
      we_data <= brd_wdata;
      we_cyc  <= cyc;
    end
    if (brd_re) begin
      re_cnt  <= re_cnt + 1;
      re_addr <= brd_addr;
    end
    if (eng_start) begin
      st_cnt <= st_cnt + 1;
      st_cyc <= cyc;
    end
    if ((brd_we || brd_re || eng_start) && eng_busy) viol <= viol + 1;
  end

  // reference model state
  logic [3:0] ref_board [64];
  logic       ref_err;
  int         rise_cyc, last_rise;

  task automatic pulse(input logic [3:0] nib);
    sdi = nib;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] cmd, input int ncmd, input int nrep,
                       output logic [15:0] rep, output logic oe_ok);
    logic       exp_oe;
    logic [3:0] nib;
    rep   = '0;
    oe_ok = 1'b1;
    cs_n  = 1'b0;
    repeat (4) @(negedge clk);
    for (int p = 0; p < ncmd + nrep; p++) begin
      if (p < ncmd) nib = cmd[4*(ncmd-1-p) +: 4];
      else          nib = 4'($urandom);
      pulse(nib);
      if (p == ncmd - 1) last_rise = rise_cyc;
      exp_oe = (nrep > 0) && (p >= ncmd - 1) && (p < ncmd - 1 + nrep);
      if (sdo_oe !== exp_oe) oe_ok = 1'b0;
      if (exp_oe) rep = {rep[11:0], sdo};
    end
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    if (sdo_oe !== 1'b0) oe_ok = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [31:0] cmd, input int ncmd, input int nrep,
                         input int exp_we, input int exp_re, input int exp_st, input logic [15:0] exp_rep);
    int         b_we, b_re, b_st;
    logic [15:0] rep;
    logic       oe_ok;
    b_we = we_cnt; b_re = re_cnt; b_st = st_cnt;
    frame(cmd, ncmd, nrep, rep, oe_ok);
    check({tag, "_we"}, 32'(we_cnt - b_we), 32'(exp_we));
    check({tag, "_re"}, 32'(re_cnt - b_re), 32'(exp_re));
    check({tag, "_start"}, 32'(st_cnt - b_st), 32'(exp_st));
    check({tag, "_oe"}, {31'h0, oe_ok}, 32'h1);
    if (nrep > 0) check({tag, "_reply"}, {16'h0, rep}, {16'h0, exp_rep});
  endtask

  function automatic logic [15:0] status_word();
    return {eng_busy, ref_err, 2'b00, eng_from, eng_to};
  endfunction

  initial begin
    logic [7:0]  a8, opc;
    logic [3:0]  d;
    logic [31:0] cmd;
    logic [15:0] exp_rep;
    int          op, ex, k, b_re;

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = '0;
    eng_busy = 1'b0; eng_from = '0; eng_to = '0;
    for (int i = 0; i < 64; i++) ref_board[i] = 4'h0;
    ref_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sdo", 32'(sdo), 32'h0);
    check("rst_sdo_oe", 32'(sdo_oe), 32'h0);
    check("rst_brd_we", 32'(brd_we), 32'h0);
    check("rst_brd_re", 32'(brd_re), 32'h0);
    check("rst_eng_start", 32'(eng_start), 32'h0);
    check("rst_brd_addr", 32'(brd_addr), 32'h0);
    check("rst_brd_wdata", 32'(brd_wdata), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // directed: write square 12 <- 5
    run_txn("wr12", 32'h010C5, 5, 0, 1, 0, 0, 16'h0);
    check("wr12_addr", 32'(we_addr), 32'd12);
    check("wr12_data", 32'(we_data), 32'd5);
    check("wr12_latency", ((we_cyc - last_rise) <= 4) ? 32'h1 : 32'h0, 32'h1);
    ref_board[12] = 4'h5;

    // directed: read square 12 back
    run_txn("rd12", 32'h020C0, 5, 1, 0, 1, 0, {12'h0, ref_board[12]});
    check("rd12_addr", 32'(re_addr), 32'd12);

    // directed: start, then status while engine searching
    run_txn("start", 32'h03, 2, 0, 0, 0, 1, 16'h0);
    check("start_latency", ((st_cyc - last_rise) <= 4) ? 32'h1 : 32'h0, 32'h1);
    eng_busy = 1'b1; eng_from = 6'd12; eng_to = 6'd28;
    run_txn("status_831c", 32'h04, 2, 4, 0, 0, 0, 16'h831C);
    run_txn("status_model", 32'h04, 2, 4, 0, 0, 0, status_word());

    // directed: refused write sets err, STATUS clears it
    run_txn("wr_busy", 32'h010C7, 5, 0, 0, 0, 0, 16'h0);
    ref_err = 1'b1;
    run_txn("status_err", 32'h04, 2, 4, 0, 0, 0, status_word());
    check("status_err_msn", 32'(status_word() >> 12), 32'hC);
    ref_err = 1'b0;
    run_txn("status_clr", 32'h04, 2, 4, 0, 0, 0, 16'h831C);
    eng_busy = 1'b0;

    // directed: aborted write, then a fresh start frame
    run_txn("abort_wr", 32'h010C, 4, 0, 0, 0, 0, 16'h0);
    run_txn("after_abort", 32'h03, 2, 0, 0, 0, 1, 16'h0);

    // directed: reset in the middle of a read frame
    b_re = re_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    pulse(4'h0); pulse(4'h2); pulse(4'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse(4'hC);
    check("rstmid_oe_a", 32'(sdo_oe), 32'h0);
    pulse(4'h0);
    check("rstmid_oe_b", 32'(sdo_oe), 32'h0);
    pulse(4'h0);
    check("rstmid_oe_c", 32'(sdo_oe), 32'h0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rstmid_re", 32'(re_cnt - b_re), 32'h0);
    ref_err = 1'b0;
    run_txn("rd_after_rst", 32'h020C0, 5, 1, 0, 1, 0, {12'h0, ref_board[12]});

    // random frames against the model
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(2) == 0) begin
        eng_busy = 1'($urandom_range(1));
        eng_from = 6'($urandom);
        eng_to   = 6'($urandom);
      end
      a8 = 8'($urandom);
      d  = 4'($urandom);
      ex = $urandom_range(2);
      op = $urandom_range(5);
      case (op)
        0: begin
          cmd = {12'h0, 8'h01, a8, d};
          cmd = (cmd << (4*ex)) | ($urandom & ((1 << (4*ex)) - 1));
          run_txn("rnd_wr", cmd, 5 + ex, 0, eng_busy ? 0 : 1, 0, 0, 16'h0);
          if (!eng_busy) begin
            check("rnd_wr_addr", 32'(we_addr), 32'(a8[5:0]));
            check("rnd_wr_data", 32'(we_data), 32'(d));
            ref_board[a8[5:0]] = d;
          end else begin
            ref_err = 1'b1;
          end
        end
        1: begin
          exp_rep = eng_busy ? 16'h000F : {12'h0, ref_board[a8[5:0]]};
          run_txn("rnd_rd", {12'h0, 8'h02, a8, d}, 5, 1, 0, eng_busy ? 0 : 1, 0, exp_rep);
          if (eng_busy) ref_err = 1'b1;
          else          check("rnd_rd_addr", 32'(re_addr), 32'(a8[5:0]));
        end
        2: begin
          cmd = (32'h03 << (4*ex)) | ($urandom & ((1 << (4*ex)) - 1));
          run_txn("rnd_start", cmd, 2 + ex, 0, 0, 0, eng_busy ? 0 : 1, 16'h0);
          if (eng_busy) ref_err = 1'b1;
        end
        3: begin
          run_txn("rnd_status", 32'h04, 2, 4, 0, 0, 0, status_word());
          ref_err = 1'b0;
        end
        4: begin
          opc = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
          run_txn("rnd_badopc", {16'h0, opc, 8'($urandom)}, 4, 0, 0, 0, 0, 16'h0);
        end
        default: begin
          k = $urandom_range(1, 4);
          cmd = {16'h0, 8'h01, a8} >> (4*(4-k));
          run_txn("rnd_abort", cmd, k, 0, 0, 0, 0, 16'h0);
        end
      endcase
    end

    eng_busy = 1'b0;
    run_txn("final_status", 32'h04, 2, 4, 0, 0, 0, status_word());
    check("strobe_while_busy", 32'(viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
